// File: rtl/ccip_rd_rsp_reorder_pkg.sv
// Shared types for the CCI-P read-response reorder buffer: the subset of
// CCI-P channel-0 types the buffer touches, the slot type and a length helper.
package ccip_rd_rsp_reorder_pkg;

   localparam int CCIP_CLDATA_WIDTH = 512;

   typedef logic [CCIP_CLDATA_WIDTH-1:0] t_ccip_clData;
   typedef logic [15:0]                  t_ccip_mdata;
   typedef logic [1:0]                   t_ccip_clNum;

   typedef enum logic [1:0] {
      eCL_LEN_1 = 2'b00,
      eCL_LEN_2 = 2'b01,
      eCL_LEN_4 = 2'b11
   } t_ccip_clLen;

   typedef enum logic [3:0] {
      eREQ_RDLINE_I = 4'h0,
      eREQ_RDLINE_S = 4'h1
   } t_ccip_c0_req;

   typedef enum logic [3:0] {
      eRSP_RDLINE = 4'h0,
      eRSP_UMSG   = 4'h4
   } t_ccip_c0_rsp;

   typedef enum logic [1:0] {
      eVC_VA  = 2'b00,
      eVC_VL0 = 2'b01,
      eVC_VH0 = 2'b10,
      eVC_VH1 = 2'b11
   } t_ccip_vc;

   typedef struct packed {
      t_ccip_vc     vc_sel;
      logic [1:0]   rsvd1;
      t_ccip_clLen  cl_len;
      t_ccip_c0_req req_type;
      logic [5:0]   rsvd0;
      logic [41:0]  address;
      t_ccip_mdata  mdata;
   } t_ccip_c0_ReqMemHdr;

   typedef struct packed {
      t_ccip_vc     vc_used;
      logic         rsvd1;
      logic         hit_miss;
      logic [1:0]   rsvd0;
      t_ccip_clNum  cl_num;
      t_ccip_c0_rsp resp_type;
      t_ccip_mdata  mdata;
   } t_ccip_c0_RspMemHdr;

   typedef struct packed {
      t_ccip_c0_ReqMemHdr hdr;
      logic               valid;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      t_ccip_c0_RspMemHdr hdr;
      t_ccip_clData       data;
      logic               rspValid;
      logic               mmioRdValid;
      logic               mmioWrValid;
   } t_if_ccip_c0_Rx;

   localparam int ROB_DEPTH  = 64;
   localparam int ROB_SLOT_W = $clog2(ROB_DEPTH);

   typedef logic [ROB_SLOT_W-1:0] t_rob_slot;

   // Number of cache lines covered by a request: 1, 2 or 4.
   function automatic logic [2:0] cl_len_to_lines(input t_ccip_clLen cl_len);
      return 3'(cl_len) + 3'd1;
   endfunction

endpackage

// File: rtl/ccip_rd_rsp_reorder_rob_sdp_ram.sv
// Simple dual-port line store: one write port and one registered read port.
// The read register holds its value while rd_en is low, so it doubles as
// the first entry of the output skid.
module rob_sdp_ram #(
   parameter int DATA_WIDTH = 512,
   parameter int DEPTH      = 64
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0]    rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read port, held when not enabled.
   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/ccip_rd_rsp_reorder.sv
// Read-response reorder buffer. Requests snooped on c0tx reserve a run of
// consecutive slots; responses on c0rx land in their slot in any order and
// lines leave strictly in slot order on a ready/valid stream.
//
// Handshake: a line transfers on every clock edge where rsp_valid and
// rsp_ready are both high; once rsp_valid rises it stays high with rsp_data
// unchanged until that transfer happens.
module ccip_rd_rsp_reorder
   import ccip_rd_rsp_reorder_pkg::*;
#(
   parameter int DATA_WIDTH     = 512,
   parameter int DEPTH          = 64,
   parameter int ALM_FULL_SLACK = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  t_if_ccip_c0_Tx        c0tx,
   input  t_if_ccip_c0_Rx        c0rx,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rob_alm_full,
   output logic                  rob_empty,
   output logic                  err_overflow,
   output logic                  err_dup
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
   localparam logic [AW+1:0] SLACK_W = (AW+2)'(ALM_FULL_SLACK);

   // Registered input stage
   logic                  tx_valid_q;
   logic [2:0]            tx_len_q;
   logic [AW-1:0]         tx_idx_q;
   logic                  rx_valid_q;
   logic [AW-1:0]         rx_idx_q;
   logic [1:0]            rx_cl_num_q;
   logic [DATA_WIDTH-1:0] rx_data_q;

   // Slot bookkeeping
   logic [AW-1:0]   tag_tbl [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [AW-1:0]   alloc_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   fetch_ptr;
   logic [AW:0]     occ;

   // Output stage: RAM read register plus one skid register ahead of it
   logic                  skid_valid;
   logic [DATA_WIDTH-1:0] skid_data;
   logic                  ram_q_valid;
   logic [DATA_WIDTH-1:0] ram_rd_data;

   logic            alloc;
   logic            overflow_evt;
   logic [AW+1:0]   occ_plus_len;
   logic [AW+1:0]   win;
   logic [AW-1:0]   tag_base;
   logic [AW-1:0]   fill_slot;
   logic [AW-1:0]   fill_off;
   logic            fill_ok;
   logic            dup_evt;
   logic            pop;
   logic [AW:0]     occ_next;
   logic [AW+1:0]   free_next;
   logic            issue;
   logic            pop_from_ram;
   logic            ram_keeps;
   logic            move;

   // Header fields this block never looks at are gathered here.
   logic unused_ok;
   assign unused_ok = ^{c0tx, c0rx};

   assign rsp_valid = skid_valid || ram_q_valid;
   assign rsp_data  = skid_valid ? skid_data : ram_rd_data;

   // Input register valids; only read-line responses are captured.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_valid_q <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         tx_valid_q <= c0tx.valid;
         rx_valid_q <= c0rx.rspValid && (c0rx.hdr.resp_type == eRSP_RDLINE);
      end
   end

   // Input register payloads.
   always_ff @(posedge clk) begin
      tx_len_q    <= cl_len_to_lines(c0tx.hdr.cl_len);
      tx_idx_q    <= c0tx.hdr.mdata[AW-1:0];
      rx_idx_q    <= c0rx.hdr.mdata[AW-1:0];
      rx_cl_num_q <= c0rx.hdr.cl_num;
      rx_data_q   <= c0rx.data[DATA_WIDTH-1:0];
   end

   // Allocation, fill legality, occupancy and output-stage steering.
   always_comb begin
      occ_plus_len = {1'b0, occ} + {{(AW-1){1'b0}}, tx_len_q};
      alloc        = tx_valid_q && (occ_plus_len <= DEPTH_W);
      overflow_evt = tx_valid_q && (occ_plus_len > DEPTH_W);
      // The window includes a run being allocated in this same cycle.
      win          = alloc ? occ_plus_len : {1'b0, occ};
      // Same-cycle allocation of the same tag wins over the stale table entry.
      tag_base     = (alloc && (tx_idx_q == rx_idx_q)) ? alloc_ptr : tag_tbl[rx_idx_q];
      fill_slot    = tag_base + {{(AW-2){1'b0}}, rx_cl_num_q};
      fill_off     = fill_slot - rd_ptr;
      fill_ok      = rx_valid_q && ({2'b00, fill_off} < win) && !vld[fill_slot];
      dup_evt      = rx_valid_q && !fill_ok;
      pop          = rsp_valid && rsp_ready;
      occ_next     = occ + (alloc ? {{(AW-2){1'b0}}, tx_len_q} : {(AW+1){1'b0}})
                         - {{AW{1'b0}}, pop};
      free_next    = DEPTH_W - {1'b0, occ_next};
      // Read ahead while the two output entries are not both occupied.
      issue        = vld[fetch_ptr] && !(skid_valid && ram_q_valid);
      pop_from_ram = pop && !skid_valid;
      ram_keeps    = ram_q_valid && !pop_from_ram;
      // An unconsumed read register about to be overwritten shifts into the skid.
      move         = issue && ram_keeps;
   end

   // Pointers, valid bits, flags and output-stage valids.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alloc_ptr    <= '0;
         rd_ptr       <= '0;
         fetch_ptr    <= '0;
         occ          <= '0;
         vld          <= '0;
         err_overflow <= 1'b0;
         err_dup      <= 1'b0;
         rob_alm_full <= 1'b0;
         rob_empty    <= 1'b1;
         skid_valid   <= 1'b0;
         ram_q_valid  <= 1'b0;
      end else begin
         if (alloc) alloc_ptr <= alloc_ptr + AW'(tx_len_q);
         if (fill_ok) vld[fill_slot] <= 1'b1;
         if (pop) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + AW'(1);
         end
         if (issue) fetch_ptr <= fetch_ptr + AW'(1);
         occ          <= occ_next;
         err_overflow <= err_overflow || overflow_evt;
         err_dup      <= err_dup || dup_evt;
         rob_alm_full <= (free_next < SLACK_W);
         rob_empty    <= (occ_next == '0);
         skid_valid   <= move || (skid_valid && !pop);
         ram_q_valid  <= issue || ram_keeps;
      end
   end

   // Tag table: base slot of each outstanding request, indexed by mdata.
   always_ff @(posedge clk) begin
      if (alloc) tag_tbl[tx_idx_q] <= alloc_ptr;
   end

   // Skid register captures the read register when it would be overwritten.
   always_ff @(posedge clk) begin
      if (move) skid_data <= ram_rd_data;
   end

   rob_sdp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (fill_ok),
      .wr_addr (fill_slot),
      .wr_data (rx_data_q),
      .rd_en   (issue),
      .rd_addr (fetch_ptr),
      .rd_data (ram_rd_data)
   );

endmodule

// File: tb/tb_ccip_rd_rsp_reorder.sv
// Directed bench for the read-response reorder buffer with a scoreboard:
// expected lines are queued when requests are issued and a monitor pops
// and compares every accepted output line.
module tb_ccip_rd_rsp_reorder;
   import ccip_rd_rsp_reorder_pkg::*;

   localparam int DW = 512;

   logic           clk = 1'b0;
   logic           reset;
   t_if_ccip_c0_Tx c0tx;
   t_if_ccip_c0_Rx c0rx;
   logic [DW-1:0]  rsp_data;
   logic           rsp_valid;
   logic           rsp_ready;
   logic           rob_alm_full;
   logic           rob_empty;
   logic           err_overflow;
   logic           err_dup;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [DW-1:0] exp_q[$];
   int            acc_q[$];

   ccip_rd_rsp_reorder #(
      .DATA_WIDTH     (DW),
      .DEPTH          (64),
      .ALM_FULL_SLACK (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .c0tx         (c0tx),
      .c0rx         (c0rx),
      .rsp_data     (rsp_data),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rob_alm_full (rob_alm_full),
      .rob_empty    (rob_empty),
      .err_overflow (err_overflow),
      .err_dup      (err_dup)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic logic [DW-1:0] mk_data(input logic [7:0] tag, input logic [1:0] cl,
                                             input logic [7:0] salt);
      logic [DW-1:0] d;
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = {salt, tag, 6'(i), cl, 8'hC3};
      return d;
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_req(input logic [15:0] md, input t_ccip_clLen len,
                           input logic [7:0] salt, input bit push);
      int n;
      n = (len == eCL_LEN_1) ? 1 : (len == eCL_LEN_2) ? 2 : 4;
      c0tx              = '0;
      c0tx.valid        = 1'b1;
      c0tx.hdr.mdata    = md;
      c0tx.hdr.cl_len   = len;
      c0tx.hdr.req_type = eREQ_RDLINE_I;
      if (push)
         for (int i = 0; i < n; i++) exp_q.push_back(mk_data(md[7:0], 2'(i), salt));
      @(posedge clk);
      #1;
      c0tx = '0;
   endtask

   task automatic send_rsp(input logic [15:0] md, input logic [1:0] cl, input logic [7:0] salt,
                           input t_ccip_c0_rsp rtype, output int at);
      c0rx               = '0;
      c0rx.rspValid      = 1'b1;
      c0rx.hdr.mdata     = md;
      c0rx.hdr.cl_num    = cl;
      c0rx.hdr.resp_type = rtype;
      c0rx.data          = mk_data(md[7:0], cl, salt);
      at = cyc;
      @(posedge clk);
      #1;
      c0rx = '0;
   endtask

   task automatic wait_valid(input int budget, output int at);
      at = -1;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic wait_drained(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_int(name, exp_q.size(), 0);
      tick(2);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (reset === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         acc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_line: got %0h expected none", rsp_data);
         end else begin
            e = exp_q.pop_front();
            check("scoreboard_data", rsp_data, e);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int t;
      int t0;
      int at;
      reset     = 1'b1;
      c0tx      = '0;
      c0rx      = '0;
      rsp_ready = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(1);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_alm_full", rob_alm_full, 0);
      check("reset_empty", rob_empty, 1);
      check("reset_err_overflow", err_overflow, 0);
      check("reset_err_dup", err_dup, 0);

      // In-order single line
      rsp_ready = 1'b1;
      send_req(16'd0, eCL_LEN_1, 8'h11, 1'b1);
      tick(2);
      check("single_not_empty", rob_empty, 0);
      send_rsp(16'd0, 2'd0, 8'h11, eRSP_RDLINE, t);
      wait_valid(20, at);
      check_int("single_latency", at, t + 3);
      tick(3);
      check("single_empty_after", rob_empty, 1);
      check_int("single_drained", exp_q.size(), 0);

      // Out-of-order lines within one request
      acc_q.delete();
      send_req(16'd1, eCL_LEN_4, 8'h22, 1'b1);
      tick(2);
      send_rsp(16'd1, 2'd3, 8'h22, eRSP_RDLINE, t);
      send_rsp(16'd1, 2'd1, 8'h22, eRSP_RDLINE, t);
      send_rsp(16'd1, 2'd0, 8'h22, eRSP_RDLINE, t0);
      send_rsp(16'd1, 2'd2, 8'h22, eRSP_RDLINE, t);
      wait_drained("ooo_drain", 50);
      check_int("ooo_count", acc_q.size(), 4);
      if (acc_q.size() == 4) begin
         check_int("ooo_first_cycle", acc_q[0], t0 + 3);
         check_int("ooo_consecutive", acc_q[3] - acc_q[0], 3);
      end

      // Cross-request reorder with an ignored non-read response
      send_req(16'd5, eCL_LEN_2, 8'h33, 1'b1);
      send_req(16'd6, eCL_LEN_1, 8'h33, 1'b1);
      tick(2);
      send_rsp(16'd5, 2'd0, 8'hEE, eRSP_UMSG, t);
      send_rsp(16'd6, 2'd0, 8'h33, eRSP_RDLINE, t);
      send_rsp(16'd5, 2'd1, 8'h33, eRSP_RDLINE, t);
      send_rsp(16'd5, 2'd0, 8'h33, eRSP_RDLINE, t);
      wait_drained("cross_drain", 50);
      check("cross_no_dup", err_dup, 0);

      // Backpressure
      rsp_ready = 1'b0;
      acc_q.delete();
      send_req(16'd7, eCL_LEN_4, 8'h44, 1'b1);
      tick(2);
      send_rsp(16'd7, 2'd2, 8'h44, eRSP_RDLINE, t);
      send_rsp(16'd7, 2'd0, 8'h44, eRSP_RDLINE, t);
      send_rsp(16'd7, 2'd3, 8'h44, eRSP_RDLINE, t);
      send_rsp(16'd7, 2'd1, 8'h44, eRSP_RDLINE, t);
      tick(5);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_valid_held", rsp_valid, 1);
         check("bp_data_stable", rsp_data, mk_data(8'd7, 2'd0, 8'h44));
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      wait_drained("bp_drain", 30);
      check_int("bp_count", acc_q.size(), 4);
      if (acc_q.size() == 4) check_int("bp_consecutive", acc_q[3] - acc_q[0], 3);

      // Threshold, overflow and wrap
      for (int i = 0; i < 14; i++) send_req(16'(8 + i), eCL_LEN_4, 8'h55, 1'b1);
      tick(2);
      check("occ56_alm_full", rob_alm_full, 0);
      send_req(16'd22, eCL_LEN_4, 8'h55, 1'b1);
      tick(2);
      check("occ60_alm_full", rob_alm_full, 1);
      send_req(16'd23, eCL_LEN_4, 8'h55, 1'b1);
      tick(2);
      check("occ64_no_overflow", err_overflow, 0);
      send_req(16'd24, eCL_LEN_4, 8'h55, 1'b0);
      tick(2);
      check("overflow_flag", err_overflow, 1);
      for (int r = 0; r < 16; r++)
         for (int c = 3; c >= 0; c--) send_rsp(16'(8 + r), 2'(c), 8'h55, eRSP_RDLINE, t);
      wait_drained("full_drain", 200);
      check("full_empty_after", rob_empty, 1);
      check("full_alm_clear", rob_alm_full, 0);
      send_req(16'd30, eCL_LEN_4, 8'h66, 1'b1);
      send_req(16'd31, eCL_LEN_2, 8'h66, 1'b1);
      tick(2);
      send_rsp(16'd31, 2'd1, 8'h66, eRSP_RDLINE, t);
      send_rsp(16'd30, 2'd2, 8'h66, eRSP_RDLINE, t);
      send_rsp(16'd31, 2'd0, 8'h66, eRSP_RDLINE, t);
      send_rsp(16'd30, 2'd0, 8'h66, eRSP_RDLINE, t);
      send_rsp(16'd30, 2'd3, 8'h66, eRSP_RDLINE, t);
      send_rsp(16'd30, 2'd1, 8'h66, eRSP_RDLINE, t);
      wait_drained("wrap_drain", 50);

      // Duplicate response
      check("pre_dup_clear", err_dup, 0);
      rsp_ready = 1'b0;
      send_req(16'd40, eCL_LEN_1, 8'h77, 1'b1);
      tick(2);
      send_rsp(16'd40, 2'd0, 8'hEE, eRSP_UMSG, t);
      tick(3);
      check("umsg_no_line", rsp_valid, 0);
      check("umsg_no_dup", err_dup, 0);
      send_rsp(16'd40, 2'd0, 8'h77, eRSP_RDLINE, t);
      send_rsp(16'd40, 2'd0, 8'h99, eRSP_RDLINE, t);
      tick(4);
      check("dup_flag", err_dup, 1);
      check("dup_valid", rsp_valid, 1);
      check("dup_data_kept", rsp_data, mk_data(8'd40, 2'd0, 8'h77));
      rsp_ready = 1'b1;
      wait_drained("dup_drain", 20);

      // Reset with lines pending
      rsp_ready = 1'b0;
      send_req(16'd41, eCL_LEN_4, 8'h88, 1'b1);
      tick(2);
      send_rsp(16'd41, 2'd0, 8'h88, eRSP_RDLINE, t);
      send_rsp(16'd41, 2'd1, 8'h88, eRSP_RDLINE, t);
      send_rsp(16'd41, 2'd2, 8'h88, eRSP_RDLINE, t);
      tick(4);
      check("pending_valid", rsp_valid, 1);
      check("pending_not_empty", rob_empty, 0);
      reset = 1'b1;
      #1;
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_alm_full", rob_alm_full, 0);
      check("midrst_empty", rob_empty, 1);
      check("midrst_err_overflow", err_overflow, 0);
      check("midrst_err_dup", err_dup, 0);
      exp_q.delete();
      tick(2);
      reset = 1'b0;
      tick(2);
      check("postrst_valid", rsp_valid, 0);

      // Fresh traffic after reset
      rsp_ready = 1'b1;
      send_req(16'd2, eCL_LEN_1, 8'h9A, 1'b1);
      tick(2);
      send_rsp(16'd2, 2'd0, 8'h9A, eRSP_RDLINE, t);
      wait_drained("postrst_drain", 20);
      check("postrst_no_dup", err_dup, 0);
      check("postrst_empty", rob_empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
